// File: rtl/uart_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_rx : 8N1 UART receiver that filters bytes against the sensor      |
// |               command set ('T', 'D') and holds one command for a handshake |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_cmd_rx #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD        = 9600,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DIV         = CLK_FREQ_HZ / (BAUD * OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       ready_to_act,
   output logic [7:0] cmd_byte,
   output logic       valid_command,
   output logic       frame_error,
   output logic       cmd_rejected,
   output logic       overrun
);

   localparam int unsigned    PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
   localparam logic [3:0]     MID_CNT    = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [7:0]     CMD_T      = 8'h54;
   localparam logic [7:0]     CMD_D      = 8'h44;
   localparam logic [7:0]     CHAR_CR    = 8'h0D;
   localparam logic [7:0]     CHAR_LF    = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic [PW-1:0]   presc_q, presc_d;
   logic [3:0]      os_q, os_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      cmd_q, cmd_d;
   logic            valid_q, valid_d;
   logic            fe_q, fe_d;
   logic            rej_q, rej_d;
   logic            ovr_q, ovr_d;
   logic            rxd_s;
   logic            tick;
   logic            mid;
   logic            is_cmd;
   logic            is_eol;

   assign rxd_s  = sync_q[1];
   assign tick   = (state_q != S_IDLE) && (presc_q == PRESC_LAST);
   assign mid    = tick && (os_q == MID_CNT);
   assign is_cmd = (shift_q == CMD_T) || (shift_q == CMD_D);
   assign is_eol = (shift_q == CHAR_CR) || (shift_q == CHAR_LF);

   always_comb begin
      state_d = state_q;
      presc_d = (state_q == S_IDLE || tick) ? '0 : presc_q + PW'(1);
      os_d    = tick ? os_q + 4'd1 : os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      cmd_d   = cmd_q;
      valid_d = valid_q && !ready_to_act;
      fe_d    = 1'b0;
      rej_d   = 1'b0;
      ovr_d   = 1'b0;

      // The sample phase runs on across START/DATA/STOP so samples stay 16 ticks apart.
      case (state_q)
         S_IDLE: begin
            os_d = 4'd0;
            if (!rxd_s) state_d = S_START;
         end
         S_START: begin
            if (mid) begin
               if (!rxd_s) begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = S_IDLE;
                  os_d    = 4'd0;
               end
            end
         end
         S_DATA: begin
            if (mid) begin
               shift_d = {rxd_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (mid) begin
               os_d = 4'd0;
               if (rxd_s) begin
                  state_d = S_IDLE;
                  if (is_cmd) begin
                     // A transfer on this same edge frees the slot for the new byte.
                     if (valid_q && !ready_to_act) begin
                        ovr_d = 1'b1;
                     end else begin
                        cmd_d   = shift_q;
                        valid_d = 1'b1;
                     end
                  end else if (!is_eol) begin
                     rej_d = 1'b1;
                  end
               end else begin
                  state_d = S_BREAK;
                  fe_d    = 1'b1;
               end
            end
         end
         S_BREAK: begin
            os_d = 4'd0;
            if (rxd_s) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            os_d    = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         presc_q <= '0;
         os_q    <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         cmd_q   <= 8'h00;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         rej_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], rxd};
         presc_q <= presc_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         cmd_q   <= cmd_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         rej_q   <= rej_d;
         ovr_q   <= ovr_d;
      end
   end

   assign cmd_byte      = cmd_q;
   assign valid_command = valid_q;
   assign frame_error   = fe_q;
   assign cmd_rejected  = rej_q;
   assign overrun       = ovr_q;

endmodule
`default_nettype wire
